// File: rtl/dtree_pkg.sv
// Shared types and sizing for the sequential decision-tree engine.
// Optional out_depth port is enabled by DTREE_PATH_LEN_EN in dtree_seq_engine.
package dtree_pkg;

   localparam int unsigned N_FEAT    = 5;
   localparam int unsigned FEAT_W    = 8;
   localparam int unsigned CLASS_W   = 5;
   localparam int unsigned N_NODES   = 32;
   localparam int unsigned MAX_DEPTH = 16;

   // Index width that stays at least one bit for degenerate sizes
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned FIDX_W  = idx_w(N_FEAT);
   localparam int unsigned PREC_W  = idx_w(FEAT_W);
   localparam int unsigned ADDR_W  = idx_w(N_NODES);
   localparam int unsigned DEPTH_W = idx_w(MAX_DEPTH + 1);

   typedef struct packed {
      logic              leaf;
      logic [FIDX_W-1:0] feat;
      logic [PREC_W-1:0] prec;
      logic [FEAT_W-1:0] thr;
      logic [ADDR_W-1:0] left;
      logic [ADDR_W-1:0] right;
   } node_t;

   localparam int unsigned NODE_W = $bits(node_t);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CLASS_W-1:0] ERR_CLASS = '1;

endpackage

// File: rtl/dtree_node_table.sv
// Node table register file: one write port, one combinational read port,
// cleared by reset.
module dtree_node_table
   import dtree_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  node_t             i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output node_t             o_rdata
);

   node_t r_mem [N_NODES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(N_NODES); i++) r_mem[i] <= '0;
      end else if (i_we && (32'(i_waddr) < N_NODES)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = (32'(i_raddr) < N_NODES) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/dtree_seq_engine.sv
// Sequential decision-tree classifier: walks the node table one node per clock.
// Define DTREE_PATH_LEN_EN to add the out_depth path-length output.
module dtree_seq_engine
   import dtree_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_FEAT*FEAT_W-1:0] in_feat,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CLASS_W-1:0]       out_class,
   output logic                     out_err,
`ifdef DTREE_PATH_LEN_EN
   output logic [DEPTH_W-1:0]       out_depth,
`endif
   input  logic                     cfg_we,
   input  logic [ADDR_W-1:0]        cfg_addr,
   input  logic [NODE_W-1:0]        cfg_node,
   output logic                     cfg_ready
);

   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
   localparam logic [PREC_W-1:0]  TOP_BIT   = PREC_W'(FEAT_W - 1);

   state_t                   r_state;
   logic [ADDR_W-1:0]        r_node;
   logic [DEPTH_W-1:0]       r_depth;
   logic [N_FEAT*FEAT_W-1:0] r_feat;
   logic                     r_out_valid;
   logic [CLASS_W-1:0]       r_out_class;
   logic                     r_out_err;

   node_t                    w_node;
   logic [FEAT_W-1:0]        w_feats [N_FEAT];
   logic [FEAT_W-1:0]        w_feat;
   logic [PREC_W-1:0]        w_shift;
   logic [FEAT_W-1:0]        w_feat_msb;
   logic [FEAT_W-1:0]        w_thr_msb;
   logic                     w_go_left;
   logic                     w_node_oob;
   logic                     w_done;
   logic [CLASS_W-1:0]       w_res_class;
   logic                     w_res_err;

   assign in_ready  = (r_state == ST_IDLE);
   assign cfg_ready = (r_state == ST_IDLE);

   dtree_node_table u_table (
      .clk     (clk),
      .rst     (rst),
      .i_we    (cfg_we && cfg_ready),
      .i_waddr (cfg_addr),
      .i_wdata (node_t'(cfg_node)),
      .i_raddr (r_node),
      .o_rdata (w_node)
   );

   always_comb begin
      for (int i = 0; i < int'(N_FEAT); i++) w_feats[i] = r_feat[i*FEAT_W +: FEAT_W];
   end

   assign w_feat = (32'(w_node.feat) < N_FEAT) ? w_feats[w_node.feat] : '0;

   // Compare only the top prec+1 bits of the feature against the low bits of thr
   assign w_shift    = TOP_BIT - w_node.prec;
   assign w_feat_msb = w_feat >> w_shift;
   assign w_thr_msb  = w_node.thr & ({FEAT_W{1'b1}} >> w_shift);
   assign w_go_left  = (w_feat_msb <= w_thr_msb);

   assign w_node_oob = (32'(r_node) >= N_NODES);
   assign w_done     = w_node_oob || w_node.leaf || (r_depth == DEPTH_MAX);
   assign w_res_err  = w_node_oob || !w_node.leaf;
   assign w_res_class = w_res_err ? ERR_CLASS : w_node.thr[CLASS_W-1:0];

`ifdef DTREE_PATH_LEN_EN
   logic [DEPTH_W-1:0] r_out_depth;
   assign out_depth = r_out_depth;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_node      <= '0;
         r_depth     <= '0;
         r_feat      <= '0;
         r_out_valid <= 1'b0;
         r_out_class <= '0;
         r_out_err   <= 1'b0;
`ifdef DTREE_PATH_LEN_EN
         r_out_depth <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_feat  <= in_feat;
                  r_node  <= '0;
                  r_depth <= '0;
                  r_state <= ST_WALK;
               end
            end
            ST_WALK: begin
               if (w_done) begin
                  r_out_class <= w_res_class;
                  r_out_err   <= w_res_err;
                  r_out_valid <= 1'b1;
`ifdef DTREE_PATH_LEN_EN
                  r_out_depth <= r_depth;
`endif
                  r_state     <= ST_DONE;
               end else begin
                  r_depth <= r_depth + DEPTH_W'(1);
                  r_node  <= w_go_left ? w_node.left : w_node.right;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_class = r_out_class;
   assign out_err   = r_out_err;

endmodule

// File: tb/tb_dtree_seq_engine.sv
// Directed self-checking bench for dtree_seq_engine (default and DTREE_PATH_LEN_EN builds).
module tb_dtree_seq_engine;
   import dtree_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     in_valid;
   logic                     in_ready;
   logic [N_FEAT*FEAT_W-1:0] in_feat;
   logic                     out_valid;
   logic                     out_ready;
   logic [CLASS_W-1:0]       out_class;
   logic                     out_err;
   logic                     cfg_we;
   logic [ADDR_W-1:0]        cfg_addr;
   logic [NODE_W-1:0]        cfg_node;
   logic                     cfg_ready;
`ifdef DTREE_PATH_LEN_EN
   logic [DEPTH_W-1:0]       out_depth;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dtree_seq_engine dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_feat   (in_feat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class),
      .out_err   (out_err),
`ifdef DTREE_PATH_LEN_EN
      .out_depth (out_depth),
`endif
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_node  (cfg_node),
      .cfg_ready (cfg_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic node_t mk_int(input int f, input int p, input int thr, input int l, input int r);
      node_t n;
      n.leaf  = 1'b0;
      n.feat  = FIDX_W'(f);
      n.prec  = PREC_W'(p);
      n.thr   = FEAT_W'(thr);
      n.left  = ADDR_W'(l);
      n.right = ADDR_W'(r);
      return n;
   endfunction

   function automatic node_t mk_leaf(input int cls);
      node_t n;
      n       = '0;
      n.leaf  = 1'b1;
      n.thr   = FEAT_W'(cls);
      return n;
   endfunction

   function automatic logic [N_FEAT*FEAT_W-1:0] pack(input int f0, input int f1, input int f2,
                                                      input int f3, input int f4);
      return {8'(f4), 8'(f3), 8'(f2), 8'(f1), 8'(f0)};
   endfunction

   task automatic write_node(input int addr, input node_t n);
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = ADDR_W'(addr);
      cfg_node = n;
      @(posedge clk);
      #1;
      cfg_we   = 1'b0;
   endtask

   task automatic program_basic();
      write_node(0, mk_int(0, 1, 8'h00, 1, 2));
      write_node(1, mk_leaf(7));
      write_node(2, mk_leaf(12));
   endtask

   // Returns just after the accepting edge
   task automatic launch(input string tag, input logic [N_FEAT*FEAT_W-1:0] f);
      @(negedge clk);
      in_feat  = f;
      in_valid = 1'b1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input int exp_lat, input int exp_cls,
                              input logic exp_err, input int exp_dep);
      int k = 0;
      while (k < 40 && !out_valid) begin
         @(posedge clk);
         #1;
         k++;
      end
      check({tag, "_lat"}, 32'(k), 32'(exp_lat));
      check({tag, "_class"}, 32'(out_class), 32'(exp_cls));
      check({tag, "_err"}, 32'(out_err), 32'(exp_err));
`ifdef DTREE_PATH_LEN_EN
      check({tag, "_depth"}, 32'(out_depth), 32'(exp_dep));
`else
      if (exp_dep < 0) check({tag, "_depth_arg"}, 32'(exp_dep), 32'd0);
`endif
   endtask

   task automatic drain(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_idle"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run(input string tag, input logic [N_FEAT*FEAT_W-1:0] f, input int lat,
                      input int cls, input logic err, input int dep);
      launch(tag, f);
      wait_result(tag, lat, cls, err, dep);
      drain(tag);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_feat = '0; out_ready = 1'b1;
      cfg_we = 1'b0; cfg_addr = '0; cfg_node = '0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      check("rst_out_class", 32'(out_class), 32'd0);
      check("rst_out_err",   32'(out_err),   32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Empty table: root self-loop trips the depth guard
      run("empty", pack(8'h12, 0, 0, 0, 0), 17, 31, 1'b1, 16);

      program_basic();
      run("p2_left",  pack(8'h3F, 8'hFF, 0, 0, 0), 2, 7, 1'b0, 1);
      run("p2_right", pack(8'h40, 0, 0, 0, 0), 2, 12, 1'b0, 1);

      // Full 8-bit precision on feature 3; equality goes left
      write_node(0, mk_int(3, 7, 8'h80, 1, 2));
      run("p8_eq", pack(8'hFF, 0, 0, 8'h80, 0), 2, 7, 1'b0, 1);
      run("p8_gt", pack(8'h00, 0, 0, 8'h81, 0), 2, 12, 1'b0, 1);

      write_node(0, mk_leaf(5));
      run("root_leaf", pack(0, 0, 0, 0, 0), 1, 5, 1'b0, 0);

      // Two-level path; thr upper bits beyond P must be ignored
      write_node(0, mk_int(1, 3, 8'hF5, 3, 1));
      write_node(3, mk_int(2, 0, 8'h00, 4, 2));
      write_node(4, mk_leaf(9));
      run("deep_ll", pack(0, 8'h50, 8'h7F, 0, 0), 3, 9, 1'b0, 2);
      run("deep_lr", pack(0, 8'h5F, 8'h80, 0, 0), 3, 12, 1'b0, 2);
      run("deep_r",  pack(0, 8'h60, 8'h00, 0, 0), 2, 7, 1'b0, 1);

      write_node(0, mk_int(0, 0, 0, 0, 0));
      run("selfloop", pack(8'hAA, 0, 0, 0, 0), 17, 31, 1'b1, 16);

      // Back-pressure: result held, new vectors ignored
      program_basic();
      out_ready = 1'b0;
      launch("bp", pack(8'h3F, 0, 0, 0, 0));
      wait_result("bp", 2, 7, 1'b0, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_feat  = pack(8'h40, 0, 0, 0, 0);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_class", 32'(out_class), 32'd7);
         check("bp_in_ready",   32'(in_ready),  32'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_still_class", 32'(out_class), 32'd7);
      drain("bp");

      // Reset in the 3rd WALK cycle clears state and table
      write_node(0, mk_int(0, 0, 0, 0, 0));
      launch("rstw", pack(0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstw_out_valid", 32'(out_valid), 32'd0);
      check("rstw_in_ready",  32'(in_ready),  32'd1);
      @(negedge clk);
      rst = 1'b0;
      run("rstw_cleared", pack(8'h3F, 0, 0, 0, 0), 17, 31, 1'b1, 16);
      program_basic();
      run("rstw_reprog", pack(8'h3F, 0, 0, 0, 0), 2, 7, 1'b0, 1);

      // Table write during WALK is dropped
      launch("cfgw", pack(8'h3F, 0, 0, 0, 0));
      @(negedge clk);
      check("cfgw_cfg_ready", 32'(cfg_ready), 32'd0);
      cfg_we = 1'b1; cfg_addr = ADDR_W'(1); cfg_node = mk_leaf(3);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      wait_result("cfgw", 1, 7, 1'b0, 1);
      drain("cfgw");
      write_node(1, mk_leaf(3));
      run("cfg_idle", pack(8'h3F, 0, 0, 0, 0), 2, 3, 1'b0, 1);

      // Same-cycle write and accept: walk sees the new node
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = ADDR_W'(1); cfg_node = mk_leaf(20);
      in_feat = pack(8'h3F, 0, 0, 0, 0); in_valid = 1'b1;
      @(posedge clk);
      #1;
      cfg_we = 1'b0; in_valid = 1'b0;
      wait_result("same_cyc", 2, 20, 1'b0, 1);
      drain("same_cyc");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
